// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and types for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;
    localparam int REG_AW   = 5;
    localparam int XLEN     = 32;
    localparam int NUM_REGS = 2 ** REG_AW;

    typedef logic [REG_AW-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t          rd;
        logic [XLEN-1:0]   data;
    } wb_beat_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin one-hot grant starting at a pointer that moves past each winner.
// Grant is combinational; no grant is issued while reset is asserted.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr;
    logic [IW-1:0] gidx;
    logic [IW:0]   cand;
    logic          found;

    always_comb begin
        gnt   = '0;
        gidx  = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!found && req[cand[IW-1:0]]) begin
                found                 = 1'b1;
                gidx                  = cand[IW-1:0];
                gnt[cand[IW-1:0]]     = 1'b1;
            end
        end
        if (!rst_n) begin
            gnt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (|gnt) begin
            ptr <= (gidx == IW'(N - 1)) ? '0 : gidx + 1'b1;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates writeback sources onto the single register-file write port and
// tracks pending writes per register for issue-stage RAW/WAW hazard checks.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = regfile_wb_arbiter_pkg::XLEN,
    parameter int REG_AW  = regfile_wb_arbiter_pkg::REG_AW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*REG_AW-1:0] req_rd,
    input  logic [NUM_REQ*XLEN-1:0] req_data,
    output logic                    rf_wr_en,
    output logic [REG_AW-1:0]       rf_write_select,
    output logic [XLEN-1:0]         rf_data_in,
    input  logic                    issue_valid,
    input  logic [REG_AW-1:0]       issue_rd,
    output logic                    issue_ready,
    input  logic                    flush,
    input  logic [REG_AW-1:0]       rs1_sel,
    input  logic [REG_AW-1:0]       rs2_sel,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
    output logic [2**REG_AW-1:0]    busy_mask
);
    import regfile_wb_arbiter_pkg::*;

    localparam int NREG = 2 ** REG_AW;

    logic [NUM_REQ-1:0] gnt;
    wb_beat_t           sel_beat;
    logic [NREG-1:0]    busy;
    logic [NREG-1:0]    busy_nxt;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .gnt   (gnt)
    );

    assign req_ready = gnt;

    always_comb begin
        sel_beat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_beat.rd   = req_rd[i*REG_AW +: REG_AW];
                sel_beat.data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // A beat to x0 is consumed but never reaches the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wr_en        <= 1'b0;
            rf_write_select <= '0;
            rf_data_in      <= '0;
        end else if (|gnt) begin
            rf_wr_en        <= (sel_beat.rd != '0);
            rf_write_select <= sel_beat.rd;
            rf_data_in      <= sel_beat.data;
        end else begin
            rf_wr_en        <= 1'b0;
        end
    end

    assign issue_ready = (issue_rd == '0) || !busy[issue_rd];
    assign rs1_busy    = busy[rs1_sel];
    assign rs2_busy    = busy[rs2_sel];
    assign busy_mask   = busy;

    // Flush wins over everything; set and clear never target the same bit.
    always_comb begin
        busy_nxt = busy;
        if (rf_wr_en) begin
            busy_nxt[rf_write_select] = 1'b0;
        end
        if (issue_valid && issue_ready && (issue_rd != '0)) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        if (flush) begin
            busy_nxt = '0;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table-driven bench for regfile_wb_arbiter plus async-reset sequence.
module tb_regfile_wb_arbiter;
    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_rd;
    logic [63:0] req_data;
    logic        rf_wr_en;
    logic [4:0]  rf_write_select;
    logic [31:0] rf_data_in;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        flush;
    logic [4:0]  rs1_sel;
    logic [4:0]  rs2_sel;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [31:0] busy_mask;

    int n_chk;
    int n_fail;

    regfile_wb_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_rd          (req_rd),
        .req_data        (req_data),
        .rf_wr_en        (rf_wr_en),
        .rf_write_select (rf_write_select),
        .rf_data_in      (rf_data_in),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .issue_ready     (issue_ready),
        .flush           (flush),
        .rs1_sel         (rs1_sel),
        .rs2_sel         (rs2_sel),
        .rs1_busy        (rs1_busy),
        .rs2_busy        (rs2_busy),
        .busy_mask       (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rv;
        logic [4:0]  rd0;
        logic [4:0]  rd1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        iv;
        logic [4:0]  ird;
        logic        fl;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [1:0]  rdy;
        logic        irdy;
        logic        b1;
        logic        b2;
        logic [31:0] mpre;
        logic        wen;
        logic        sd;
        logic [4:0]  wsel;
        logic [31:0] wdat;
        logic [31:0] mpost;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        req_valid   = 2'b00;
        req_rd      = '0;
        req_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        flush       = 1'b0;
        rs1_sel     = '0;
        rs2_sel     = '0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        idle_inputs();
        rst_n     = 1'b0;
        req_valid = 2'b11;

        //          rv    rd0 rd1 d0            d1            iv ird fl rs1 rs2  rdy   irdy b1 b2 mpre        wen sd wsel wdat          mpost
        vecs.push_back('{2'b00, 0, 0, 32'h0,        32'h0,        1, 5,  0, 5,  0,  2'b00, 1, 0, 0, 32'h0,      0, 0, 0, 32'h0,        32'h20});
        vecs.push_back('{2'b01, 5, 0, 32'hDEADBEEF, 32'h0,        0, 0,  0, 5,  0,  2'b01, 1, 1, 0, 32'h20,     1, 1, 5, 32'hDEADBEEF, 32'h20});
        vecs.push_back('{2'b00, 0, 0, 32'h0,        32'h0,        0, 0,  0, 5,  0,  2'b00, 1, 1, 0, 32'h20,     0, 1, 5, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{2'b00, 0, 0, 32'h0,        32'h0,        0, 0,  0, 5,  0,  2'b00, 1, 0, 0, 32'h0,      0, 1, 5, 32'hDEADBEEF, 32'h0});
        // both requesters continuously valid; pointer is 1 here
        vecs.push_back('{2'b11, 3, 4, 32'hA0,       32'hB1,       0, 0,  0, 0,  0,  2'b10, 1, 0, 0, 32'h0,      1, 1, 4, 32'hB1,       32'h0});
        vecs.push_back('{2'b11, 3, 4, 32'hA0,       32'hB1,       0, 0,  0, 0,  0,  2'b01, 1, 0, 0, 32'h0,      1, 1, 3, 32'hA0,       32'h0});
        vecs.push_back('{2'b11, 3, 4, 32'hA0,       32'hB1,       0, 0,  0, 0,  0,  2'b10, 1, 0, 0, 32'h0,      1, 1, 4, 32'hB1,       32'h0});
        vecs.push_back('{2'b11, 3, 4, 32'hA0,       32'hB1,       0, 0,  0, 0,  0,  2'b01, 1, 0, 0, 32'h0,      1, 1, 3, 32'hA0,       32'h0});
        // WAW on x7
        vecs.push_back('{2'b00, 0, 0, 32'h0,        32'h0,        1, 7,  0, 7,  0,  2'b00, 1, 0, 0, 32'h0,      0, 0, 0, 32'h0,        32'h80});
        vecs.push_back('{2'b00, 0, 0, 32'h0,        32'h0,        1, 7,  0, 7,  0,  2'b00, 0, 1, 0, 32'h80,     0, 0, 0, 32'h0,        32'h80});
        vecs.push_back('{2'b10, 0, 7, 32'h0,        32'h77,       1, 7,  0, 7,  0,  2'b10, 0, 1, 0, 32'h80,     1, 1, 7, 32'h77,       32'h80});
        vecs.push_back('{2'b00, 0, 0, 32'h0,        32'h0,        1, 7,  0, 7,  0,  2'b00, 0, 1, 0, 32'h80,     0, 0, 0, 32'h0,        32'h0});
        vecs.push_back('{2'b00, 0, 0, 32'h0,        32'h0,        1, 7,  0, 7,  0,  2'b00, 1, 0, 0, 32'h0,      0, 0, 0, 32'h0,        32'h80});
        // writeback to x0 and issue of x0
        vecs.push_back('{2'b01, 0, 0, 32'h1234,     32'h0,        1, 0,  0, 0,  0,  2'b01, 1, 0, 0, 32'h80,     0, 0, 0, 32'h0,        32'h80});
        vecs.push_back('{2'b00, 0, 0, 32'h0,        32'h0,        1, 0,  0, 0,  0,  2'b00, 1, 0, 0, 32'h80,     0, 0, 0, 32'h0,        32'h80});
        // busy x1, x2, x9 then flush alongside an issue of x10
        vecs.push_back('{2'b00, 0, 0, 32'h0,        32'h0,        1, 1,  0, 1,  0,  2'b00, 1, 0, 0, 32'h80,     0, 0, 0, 32'h0,        32'h82});
        vecs.push_back('{2'b00, 0, 0, 32'h0,        32'h0,        1, 2,  0, 1,  0,  2'b00, 1, 1, 0, 32'h82,     0, 0, 0, 32'h0,        32'h86});
        vecs.push_back('{2'b10, 0, 2, 32'h0,        32'h22,       1, 9,  0, 2,  0,  2'b10, 1, 1, 0, 32'h86,     1, 1, 2, 32'h22,       32'h286});
        vecs.push_back('{2'b00, 0, 0, 32'h0,        32'h0,        1, 10, 1, 2,  9,  2'b00, 1, 1, 1, 32'h286,    0, 1, 2, 32'h22,       32'h0});
        vecs.push_back('{2'b00, 0, 0, 32'h0,        32'h0,        0, 0,  0, 10, 2,  2'b00, 1, 0, 0, 32'h0,      0, 0, 0, 32'h0,        32'h0});

        // reset state, with requests pending to prove no grant in reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(rf_wr_en), 32'h0);
        chk("rst_wsel", 32'(rf_write_select), 32'h0);
        chk("rst_wdat", rf_data_in, 32'h0);
        chk("rst_busy", busy_mask, 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);

        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            req_valid   = vecs[i].rv;
            req_rd      = {vecs[i].rd1, vecs[i].rd0};
            req_data    = {vecs[i].d1, vecs[i].d0};
            issue_valid = vecs[i].iv;
            issue_rd    = vecs[i].ird;
            flush       = vecs[i].fl;
            rs1_sel     = vecs[i].rs1;
            rs2_sel     = vecs[i].rs2;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d_issue_ready", i), 32'(issue_ready), 32'(vecs[i].irdy));
            chk($sformatf("v%0d_rs1_busy", i), 32'(rs1_busy), 32'(vecs[i].b1));
            chk($sformatf("v%0d_rs2_busy", i), 32'(rs2_busy), 32'(vecs[i].b2));
            chk($sformatf("v%0d_mask_pre", i), busy_mask, vecs[i].mpre);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wr_en", i), 32'(rf_wr_en), 32'(vecs[i].wen));
            if (vecs[i].sd) begin
                chk($sformatf("v%0d_wsel", i), 32'(rf_write_select), 32'(vecs[i].wsel));
                chk($sformatf("v%0d_wdat", i), rf_data_in, vecs[i].wdat);
            end
            chk($sformatf("v%0d_mask_post", i), busy_mask, vecs[i].mpost);
            @(negedge clk);
        end

        // async reset while a write sits in the output stage; pointer is left at 1
        idle_inputs();
        req_valid   = 2'b01;
        req_rd      = {5'd0, 5'd6};
        req_data    = {32'h0, 32'h66};
        issue_valid = 1'b1;
        issue_rd    = 5'd12;
        @(posedge clk);
        #1;
        chk("ar_wr_en_before", 32'(rf_wr_en), 32'h1);
        chk("ar_mask_before", busy_mask, 32'h1000);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_wr_en_drop", 32'(rf_wr_en), 32'h0);
        chk("ar_wsel_drop", 32'(rf_write_select), 32'h0);
        chk("ar_mask_drop", busy_mask, 32'h0);
        chk("ar_ready_in_rst", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst_n       = 1'b1;
        issue_valid = 1'b0;
        req_valid   = 2'b11;
        req_rd      = {5'd4, 5'd3};
        #1;
        chk("ar_ptr_reset", 32'(req_ready), 32'h1);
        chk("ar_mask_after", busy_mask, 32'h0);
        @(posedge clk);
        #1;
        chk("ar_first_wsel", 32'(rf_write_select), 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
